hash_uut_sequencer: RTL and testbench
=====================================

Name: hash_uut_sequencer

Overview:
- Parametrised successor to the single-shot hash UUT hookup: drives a hash core UUT (for example the Hirose-PRESENT wrapper) over multi-block messages, feeding each block's hash back as the chaining value for the next.
- Measures cycles per message, applies a per-block timeout, compares the final digest with an expected value and exports a 32-bit debug word for the 7-segment display.
- Sits between the SD/SPI autotest controller (block source, result sink) and the UUT.

Parameters:
- DATA_WIDTH, 64, UUT message-block width.
- HASH_WIDTH, 128, UUT digest and chaining width.
- MAX_BLOCKS, 8, maximum blocks per message; BW = $clog2(MAX_BLOCKS+1).
- RST_CYCLES, 2, cycles rst_uut_o is held high before each block (≥1).
- TIMEOUT_CYCLES, 65535, maximum RUN cycles per block before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse that starts a message; sampled only in IDLE or DONE.
- n_blocks_i  in  BW  block count, sampled on start.
- block_req_o  out  1  requests the next message block.
- block_valid_i  in  1  block_data_i is valid; transfer occurs when block_req_o && block_valid_i.
- block_data_i  in  DATA_WIDTH  message block.
- expected_i  in  HASH_WIDTH  reference digest, sampled on start.
- rst_uut_o  out  1  UUT reset.
- plaintext_uut_o  out  DATA_WIDTH  current block to the UUT.
- chain_uut_o  out  HASH_WIDTH  chaining value to the UUT; 0 for the first block.
- end_uut_i  in  1  UUT finished.
- hash_uut_i  in  HASH_WIDTH  UUT digest.
- busy_o  out  1  message in progress.
- done_o  out  1  result valid; held until the next accepted start.
- pass_o  out  1  final digest == expected.
- timeout_o  out  1  a block exceeded TIMEOUT_CYCLES.
- hash_o  out  HASH_WIDTH  last captured digest.
- cycles_o  out  32  total RUN cycles for the message, saturating.
- debug_o  out  32  {pass_o, timeout_o, busy_o, done_o, block_idx[3:0] zero-extended, cycles_o[23:0]}.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state goes to IDLE.
  - rst_uut_o=1.
  - block_req_o, busy_o, done_o, pass_o, timeout_o = 0.
  - hash_o, chain_uut_o, plaintext_uut_o, cycles_o = 0; block_idx = 0.
  - Reset mid-message aborts immediately; no partial result is kept.
- State machine:
  - IDLE: rst_uut_o=1.
    - start_i=1: latch n (n_blocks_i saturated to MAX_BLOCKS) and expected_i; clear cycles_o, chain, block_idx, done_o, pass_o, timeout_o; busy_o=1 from the next cycle.
    - If n==0: go to DONE with pass_o=0, hash_o=0.
    - Otherwise go to FETCH.
  - FETCH: block_req_o=1; rst_uut_o=1.
    - On transfer: latch plaintext_uut_o <= block_data_i and go to RSTU.
    - block_req_o drops the cycle after the transfer.
    - Waits indefinitely for block_valid_i; no timeout applies here.
  - RSTU: rst_uut_o=1 for exactly RST_CYCLES cycles, then go to RUN.
    - plaintext_uut_o and chain_uut_o are stable from FETCH exit until CAPTURE.
  - RUN: rst_uut_o=0. Each cycle, the block counter and cycles_o increment; cycles_o saturates at 2^32-1.
    - end_uut_i=1: go to CAPTURE. The cycle in which end is seen is counted.
    - Block counter reaches TIMEOUT_CYCLES without end: go to DONE with timeout_o=1, pass_o=0, hash_o unchanged.
    - end_uut_i is ignored in every state except RUN.
  - CAPTURE: hash_o <= hash_uut_i; chain_uut_o <= hash_uut_i; block_idx++.
    - If block_idx+1 == n: go to CHECK. Otherwise go to FETCH.
  - CHECK: pass_o <= (hash_o == expected latched); go to DONE.
  - DONE: done_o=1, busy_o=0, rst_uut_o=1. Outputs hold.
    - start_i=1 behaves as in IDLE, including clearing done_o the next cycle.
- Timing and precedence:
  - start_i is ignored while busy_o=1.
  - Minimum latency per block = 1 (FETCH with valid already high) + RST_CYCLES + UUT cycles + 1 (CAPTURE). CHECK adds 1 cycle per message.
  - Simultaneous end_uut_i and timeout in the same cycle: end wins.
- Width rules:
  - The digest comparison is full HASH_WIDTH.
  - debug block_idx field is block_idx[3:0] when BW≥4; otherwise it is zero-padded.

Test Plan:
- Single block: n=1, block 64'h0 (valid held high), UUT model ends after 32 cycles returning 128'hA5…A5, expected_i=128'hA5…A5.
  - Required: rst_uut_o high for 2 cycles; done_o=1, pass_o=1, cycles_o=32, chain_uut_o=0 during RUN.
- Chaining: n=3, model returns hash = chain ^ {2{plaintext}}, blocks 1,2,3, expected = that XOR chain.
  - Required: chain_uut_o for block 2 equals hash of block 1; pass_o=1; debug_o[27:24]=3.
- Mismatch: same as the single-block case but expected_i=0. Required: pass_o=0, timeout_o=0, done_o=1, hash_o=128'hA5…A5.
- Timeout: TIMEOUT_CYCLES=100, model never ends. Required: DONE after 100 RUN cycles, timeout_o=1, pass_o=0, cycles_o=100.
- Edge cases:
  - n_blocks_i=0: done_o two cycles after start, pass_o=0.
  - n_blocks_i=15 with MAX_BLOCKS=8: exactly 8 transfers.
  - block_valid_i delayed 10 cycles: block_req_o held for those cycles.
- Abort/restart: assert rst during RUN of block 2. Required: next cycle all outputs at reset values. start_i while busy is ignored; start_i in DONE restarts and done_o clears.

Source files
------------

// File: rtl/hash_uut_sequencer.sv
// Multi-block hash UUT sequencer: feeds blocks, chains digests,
// times each message and checks the final digest.
module hash_uut_sequencer #(
  parameter int DATA_WIDTH     = 64,
  parameter int HASH_WIDTH     = 128,
  parameter int MAX_BLOCKS     = 8,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int BW = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BW-1:0]         n_blocks_i,
  output logic                  block_req_o,
  input  logic                  block_valid_i,
  input  logic [DATA_WIDTH-1:0] block_data_i,
  input  logic [HASH_WIDTH-1:0] expected_i,
  output logic                  rst_uut_o,
  output logic [DATA_WIDTH-1:0] plaintext_uut_o,
  output logic [HASH_WIDTH-1:0] chain_uut_o,
  input  logic                  end_uut_i,
  input  logic [HASH_WIDTH-1:0] hash_uut_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [HASH_WIDTH-1:0] hash_o,
  output logic [31:0]           cycles_o,
  output logic [31:0]           debug_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, RSTU, RUN, CAPTURE, CHECK, DONE
  } state_t;

  state_t                state;
  logic [BW-1:0]         idx;
  logic [BW-1:0]         n_r;
  logic [BW-1:0]         n_sat;
  logic [HASH_WIDTH-1:0] exp_r;
  logic [TW-1:0]         bcnt;
  logic [RW-1:0]         rcnt;
  logic [3:0]            idx4;

  always_comb begin
    n_sat = n_blocks_i;
    if (n_blocks_i > BW'(MAX_BLOCKS))
      n_sat = BW'(MAX_BLOCKS);
  end

  assign idx4    = 4'(idx);
  assign debug_o = {pass_o, timeout_o, busy_o, done_o,
                    idx4, cycles_o[23:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rst_uut_o       <= 1'b1;
      block_req_o     <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      timeout_o       <= 1'b0;
      hash_o          <= '0;
      chain_uut_o     <= '0;
      plaintext_uut_o <= '0;
      cycles_o        <= '0;
      idx             <= '0;
      n_r             <= '0;
      exp_r           <= '0;
      bcnt            <= '0;
      rcnt            <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          rst_uut_o <= 1'b1;
          if (start_i) begin
            n_r         <= n_sat;
            exp_r       <= expected_i;
            cycles_o    <= '0;
            chain_uut_o <= '0;
            idx         <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            if (n_sat == '0) begin
              // empty message: immediate failing result
              hash_o <= '0;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= DONE;
            end else begin
              busy_o      <= 1'b1;
              block_req_o <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          rst_uut_o <= 1'b1;
          if (block_valid_i) begin
            plaintext_uut_o <= block_data_i;
            block_req_o     <= 1'b0;
            rcnt            <= '0;
            state           <= RSTU;
          end
        end
        RSTU: begin
          if (rcnt == RW'(RST_CYCLES - 1)) begin
            rst_uut_o <= 1'b0;
            bcnt      <= '0;
            state     <= RUN;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        RUN: begin
          bcnt <= bcnt + TW'(1);
          if (cycles_o != '1)
            cycles_o <= cycles_o + 32'd1;
          // end takes precedence over a coincident timeout
          if (end_uut_i) begin
            rst_uut_o <= 1'b1;
            state     <= CAPTURE;
          end else if (bcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rst_uut_o <= 1'b1;
            timeout_o <= 1'b1;
            pass_o    <= 1'b0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= DONE;
          end
        end
        CAPTURE: begin
          hash_o      <= hash_uut_i;
          chain_uut_o <= hash_uut_i;
          idx         <= idx + BW'(1);
          if (idx + BW'(1) == n_r) begin
            state <= CHECK;
          end else begin
            block_req_o <= 1'b1;
            state       <= FETCH;
          end
        end
        CHECK: begin
          pass_o <= (hash_o == exp_r);
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_uut_sequencer.sv
// Scoreboard bench for hash_uut_sequencer with a behavioural
// hash UUT model (constant or XOR-chaining digest).
module tb_hash_uut_sequencer;

  localparam int DW = 64;
  localparam int HW = 128;
  localparam int TO = 100;
  localparam logic [HW-1:0] A5 = {16{8'hA5}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [3:0]    n_blocks_i = '0;
  logic          block_req_o;
  logic          block_valid_i = 1'b0;
  logic [DW-1:0] block_data_i = '0;
  logic [HW-1:0] expected_i = '0;
  logic          rst_uut_o;
  logic [DW-1:0] plaintext_uut_o;
  logic [HW-1:0] chain_uut_o;
  logic          end_uut_i;
  logic [HW-1:0] hash_uut_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [HW-1:0] hash_o;
  logic [31:0]   cycles_o, debug_o;

  int n_chk = 0;
  int n_fail = 0;

  // UUT model controls
  int   lat = 32;
  logic a5_mode = 1'b1;
  logic never_end = 1'b0;
  int   ucnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    ucnt <= rst_uut_o ? 0 : ucnt + 1;

  assign end_uut_i = !rst_uut_o && !never_end && (ucnt == lat - 1);
  assign hash_uut_i = a5_mode ? A5
                    : chain_uut_o ^ {2{plaintext_uut_o}};

  hash_uut_sequencer #(
    .DATA_WIDTH(DW), .HASH_WIDTH(HW), .MAX_BLOCKS(8),
    .RST_CYCLES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .block_req_o(block_req_o),
    .block_valid_i(block_valid_i), .block_data_i(block_data_i),
    .expected_i(expected_i), .rst_uut_o(rst_uut_o),
    .plaintext_uut_o(plaintext_uut_o), .chain_uut_o(chain_uut_o),
    .end_uut_i(end_uut_i), .hash_uut_i(hash_uut_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .hash_o(hash_o),
    .cycles_o(cycles_o), .debug_o(debug_o)
  );

  typedef struct packed {
    logic          pass;
    logic          to;
    logic [HW-1:0] hash;
    logic [31:0]   cycles;
    logic [3:0]    idx;
  } exp_t;

  typedef struct packed {
    logic          done_seen;
    logic          done_low;
    logic          aborted;
    logic          pass;
    logic          to;
    logic [HW-1:0] hash;
    logic [31:0]   cycles;
    logic [31:0]   debug;
    int            done_lat;
    int            xfers;
    int            req_first;
    int            rstu_len;
  } obs_t;

  exp_t          exp_q[$];
  logic [HW-1:0] chain_q[$];
  logic [HW-1:0] obs_chain[$];
  logic [DW-1:0] blk[16];
  logic [HW-1:0] last_hash = '0;

  function automatic logic [31:0] dbg(input exp_t e);
    return {e.pass, e.to, 2'b01, e.idx, e.cycles[23:0]};
  endfunction

  // push expected digest chain and result for blocks blk[0..n-1]
  task automatic push_xor(input int n);
    logic [HW-1:0] h;
    exp_t e;
    h = '0;
    chain_q.delete();
    for (int i = 0; i < n; i++) begin
      chain_q.push_back(h);
      h = h ^ {2{blk[i]}};
    end
    e = {1'b1, 1'b0, h, 32'(n * lat), 4'(n)};
    exp_q.push_back(e);
    expected_i = h;
  endtask

  // drives one message and records what the DUT did
  task automatic run_msg(input int nb, input logic [HW-1:0] ex,
                         input int dly, input int budget,
                         input int busy_start_at, input int abort_blk,
                         output obs_t o);
    int   tidx, reqc, cyc, rstc;
    logic xfer, cnt_rst, rst_prev;
    o = '0;
    tidx = 0; reqc = 0; rstc = 0;
    xfer = 0; cnt_rst = 0; rst_prev = 1;
    obs_chain.delete();
    @(negedge clk);
    n_blocks_i    = 4'(nb);
    expected_i    = ex;
    block_valid_i = 1'b0;
    block_data_i  = blk[0];
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      if (done_o) begin
        o.done_seen = 1; o.done_lat = cyc;
        o.pass = pass_o; o.to = timeout_o;
        o.hash = hash_o; o.cycles = cycles_o;
        o.debug = debug_o;
        break;
      end
      o.done_low = 1;
      if (xfer) begin
        tidx++; reqc = 0; cnt_rst = 1; rstc = 0;
      end
      if (cnt_rst) begin
        if (rst_uut_o) rstc++;
        else begin
          if (tidx == 1) o.rstu_len = rstc;
          cnt_rst = 0;
        end
      end
      if (rst_prev && !rst_uut_o) obs_chain.push_back(chain_uut_o);
      if (abort_blk > 0 && !rst_uut_o &&
          obs_chain.size() == abort_blk) begin
        rst = 1'b1; o.aborted = 1;
        break;
      end
      rst_prev = rst_uut_o;
      if (block_req_o) begin
        reqc++;
        if (tidx == 0) o.req_first++;
      end
      block_valid_i = (dly == 0) ? 1'b1 : (block_req_o && reqc > dly);
      block_data_i  = blk[tidx % 16];
      xfer = block_req_o && block_valid_i;
      if (xfer) o.xfers++;
      if (cyc == busy_start_at) begin
        start_i = 1'b1; n_blocks_i = '0;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    block_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({rst_uut_o, block_req_o, busy_o, done_o, pass_o, timeout_o}
        !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {rst_uut_o, block_req_o, busy_o, done_o, pass_o, timeout_o});
    end
    n_chk++;
    if ({hash_o, chain_uut_o, plaintext_uut_o, cycles_o, debug_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got hash %h cycles %0d dbg %h want 0",
               hash_o, cycles_o, debug_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_block();
    exp_t e; obs_t o;
    a5_mode = 1; never_end = 0; lat = 32; blk[0] = '0;
    e = {1'b1, 1'b0, A5, 32'd32, 4'd1};
    exp_q.push_back(e);
    run_msg(1, A5, 0, 200, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.done_seen !== 1'b1 || o.pass !== e.pass) begin
      n_fail++;
      $display("FAIL single_pass: done %0b pass %0b want 1 1", o.done_seen, o.pass);
    end
    n_chk++;
    if (o.rstu_len !== 2) begin
      n_fail++;
      $display("FAIL single_rstu: got %0d want 2", o.rstu_len);
    end
    n_chk++;
    if (o.cycles !== e.cycles || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL single_result: cycles %0d hash %h want %0d %h",
               o.cycles, o.hash, e.cycles, e.hash);
    end
    n_chk++;
    if (obs_chain.size() !== 1 || obs_chain[0] !== '0) begin
      n_fail++;
      $display("FAIL single_chain: got %h want 0", obs_chain[0]);
    end
    n_chk++;
    if (o.debug !== dbg(e)) begin
      n_fail++;
      $display("FAIL single_debug: got %h want %h", o.debug, dbg(e));
    end
    last_hash = e.hash;
  endtask

  task automatic test_mismatch();
    exp_t e; obs_t o;
    a5_mode = 1; lat = 32; blk[0] = '0;
    e = {1'b0, 1'b0, A5, 32'd32, 4'd1};
    exp_q.push_back(e);
    run_msg(1, '0, 0, 200, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.done_seen !== 1'b1 || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL mismatch_hash: done %0b hash %h want 1 %h",
               o.done_seen, o.hash, e.hash);
    end
    n_chk++;
    if (o.debug !== dbg(e) || o.done_low !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_debug: got %h low %0b want %h 1",
               o.debug, o.done_low, dbg(e));
    end
    last_hash = e.hash;
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o;
    a5_mode = 1; never_end = 1;
    e = {1'b0, 1'b1, last_hash, 32'(TO), 4'd0};
    exp_q.push_back(e);
    run_msg(1, A5, 0, 400, -1, 0, o);
    e = exp_q.pop_front();
    never_end = 0;
    n_chk++;
    if (o.done_seen !== 1'b1 || o.to !== 1'b1 || o.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: done %0b to %0b pass %0b want 1 1 0",
               o.done_seen, o.to, o.pass);
    end
    n_chk++;
    if (o.cycles !== e.cycles || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL timeout_result: cycles %0d hash %h want %0d %h",
               o.cycles, o.hash, e.cycles, e.hash);
    end
    n_chk++;
    if (o.debug !== dbg(e)) begin
      n_fail++;
      $display("FAIL timeout_debug: got %h want %h", o.debug, dbg(e));
    end
  endtask

  task automatic test_end_vs_timeout();
    exp_t e; obs_t o;
    a5_mode = 1; lat = TO;
    e = {1'b1, 1'b0, A5, 32'(TO), 4'd1};
    exp_q.push_back(e);
    run_msg(1, A5, 0, 400, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.done_seen !== 1'b1 || o.debug !== dbg(e)) begin
      n_fail++;
      $display("FAIL end_wins: done %0b dbg %h want 1 %h",
               o.done_seen, o.debug, dbg(e));
    end
    last_hash = e.hash;
  endtask

  task automatic test_chaining();
    exp_t e; obs_t o;
    logic [HW-1:0] c;
    a5_mode = 0; lat = 32;
    blk[0] = 64'd1; blk[1] = 64'd2; blk[2] = 64'd3;
    push_xor(3);
    run_msg(3, expected_i, 0, 400, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (obs_chain.size() !== 3) begin
      n_fail++;
      $display("FAIL chain_count: got %0d want 3", obs_chain.size());
    end
    for (int i = 0; i < 3; i++) begin
      c = chain_q.pop_front();
      n_chk++;
      if (obs_chain[i] !== c) begin
        n_fail++;
        $display("FAIL chain_blk%0d: got %h want %h", i, obs_chain[i], c);
      end
    end
    n_chk++;
    if (o.done_seen !== 1'b1 || o.debug !== dbg(e) || o.debug[27:24] !== 4'd3) begin
      n_fail++;
      $display("FAIL chain_debug: got %h want %h", o.debug, dbg(e));
    end
    last_hash = e.hash;
  endtask

  task automatic test_zero_blocks();
    exp_t e; obs_t o;
    e = {1'b0, 1'b0, {HW{1'b0}}, 32'd0, 4'd0};
    exp_q.push_back(e);
    run_msg(0, A5, 0, 20, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.done_seen !== 1'b1 || o.done_lat < 1 || o.done_lat > 2) begin
      n_fail++;
      $display("FAIL zero_latency: done %0b lat %0d want 1 within 2",
               o.done_seen, o.done_lat);
    end
    n_chk++;
    if (o.debug !== dbg(e) || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL zero_result: dbg %h hash %h want %h 0",
               o.debug, o.hash, dbg(e));
    end
    last_hash = e.hash;
  endtask

  task automatic test_saturation();
    exp_t e; obs_t o;
    a5_mode = 0; lat = 5;
    for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    push_xor(8);
    run_msg(15, expected_i, 0, 600, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.xfers !== 8) begin
      n_fail++;
      $display("FAIL sat_xfers: got %0d want 8", o.xfers);
    end
    n_chk++;
    if (o.done_seen !== 1'b1 || o.debug !== dbg(e) || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL sat_result: dbg %h hash %h want %h %h",
               o.debug, o.hash, dbg(e), e.hash);
    end
    last_hash = e.hash;
  endtask

  task automatic test_delayed_valid();
    exp_t e; obs_t o;
    a5_mode = 0; lat = 8;
    blk[0] = {$urandom, $urandom};
    push_xor(1);
    run_msg(1, expected_i, 10, 300, -1, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.req_first !== 11) begin
      n_fail++;
      $display("FAIL delay_req: got %0d cycles want 11", o.req_first);
    end
    n_chk++;
    if (o.done_seen !== 1'b1 || o.debug !== dbg(e)) begin
      n_fail++;
      $display("FAIL delay_result: dbg %h want %h", o.debug, dbg(e));
    end
  endtask

  task automatic test_busy_start();
    exp_t e; obs_t o;
    a5_mode = 0; lat = 8;
    blk[0] = {$urandom, $urandom}; blk[1] = {$urandom, $urandom};
    push_xor(2);
    run_msg(2, expected_i, 0, 300, 6, 0, o);
    e = exp_q.pop_front();
    n_chk++;
    if (o.done_seen !== 1'b1 || o.debug !== dbg(e) || o.hash !== e.hash) begin
      n_fail++;
      $display("FAIL busy_start: dbg %h hash %h want %h %h",
               o.debug, o.hash, dbg(e), e.hash);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    a5_mode = 0; lat = 10;
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom};
    run_msg(3, A5, 0, 300, -1, 2, o);
    @(negedge clk);
    n_chk++;
    if (o.aborted !== 1'b1 ||
        {rst_uut_o, block_req_o, busy_o, done_o, pass_o, timeout_o}
        !== 6'b100000) begin
      n_fail++;
      $display("FAIL abort_ctrl: reached %0b got %b want 1 100000", o.aborted,
               {rst_uut_o, block_req_o, busy_o, done_o, pass_o, timeout_o});
    end
    n_chk++;
    if ({hash_o, chain_uut_o, plaintext_uut_o, cycles_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_data: hash %h chain %h cycles %0d want 0",
               hash_o, chain_uut_o, cycles_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o;
    a5_mode = 0; lat = 6;
    for (int k = 0; k < 2; k++) begin
      blk[0] = {$urandom, $urandom};
      push_xor(1);
      run_msg(1, expected_i, 0, 200, -1, 0, o);
      e = exp_q.pop_front();
      n_chk++;
      if (o.done_seen !== 1'b1 || o.done_low !== 1'b1 ||
          o.debug !== dbg(e) || o.hash !== e.hash) begin
        n_fail++;
        $display("FAIL b2b_%0d: low %0b dbg %h want 1 %h",
                 k, o.done_low, o.debug, dbg(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_mismatch();
    test_timeout();
    test_end_vs_timeout();
    test_chaining();
    test_zero_blocks();
    test_saturation();
    test_delayed_valid();
    test_busy_start();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
